// File: rtl/bram_stream_reader_if.sv
// Memory read port and output stream of bram_stream_reader.
// master = reader side, slave = memory plus stream sink side.
interface bram_stream_reader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [15:0]       mem_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_data;
  logic              m_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader: streams count words from a 1-cycle-latency BRAM through a 2-entry FIFO.
// Optional running checksum enabled by defining BRAM_READER_CHECKSUM_EN.
module bram_stream_reader #(
  parameter int unsigned NUM_BLOCKS = 16,
  localparam int unsigned ADDR_W = 8 + $clog2(NUM_BLOCKS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic [15:0]         checksum,
  bram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   issue_left_q;
  logic [ADDR_W:0]   words_left_q;
  logic              rd_pend_q;
  logic [15:0]       fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;
  logic              done_q, done_d;

  logic              accept, rd_en, valid, xfer;
  logic [1:0]        credit;
  logic [15:0]       data;

  assign valid  = (occ_q != 2'd0);
  assign xfer   = valid & bus.m_ready;
  assign data   = valid ? fifo_q[rd_ptr_q] : 16'h0000;
  // A word leaving this cycle frees its slot, which keeps reads back to back.
  assign credit = occ_q + {1'b0, rd_pend_q} - {1'b0, xfer};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rd_en = (credit < 2'd2);
        if (rd_en && issue_left_q == CntOne) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (xfer && words_left_q == CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      words_left_q <= '0;
      rd_pend_q    <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= '0;
    end else begin
      rd_pend_q <= rd_en;
      if (accept) begin
        rd_addr_q    <= base_addr;
        issue_left_q <= count;
        words_left_q <= count;
      end
      if (rd_en) begin
        rd_addr_q    <= rd_addr_q + AddrOne;
        issue_left_q <= issue_left_q - CntOne;
      end
      if (rd_pend_q) begin
        fifo_q[wr_ptr_q] <= bus.mem_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q     <= ~rd_ptr_q;
        words_left_q <= words_left_q - CntOne;
      end
      occ_q <= occ_q + {1'b0, rd_pend_q} - {1'b0, xfer};
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.m_valid     = valid;
  assign bus.m_data      = data;
  assign bus.m_last      = valid && (words_left_q == CntOne);

`ifdef BRAM_READER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (xfer) begin
      checksum_q <= checksum_q + data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: timing, stalls, wrap, zero count, reset, checksum.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] count;
  logic        busy, done;
  logic [15:0] checksum;

  bram_stream_reader_if #(.ADDR_W(12)) bus ();

  bram_stream_reader #(.NUM_BLOCKS(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one-cycle read latency, word = 0x5000 | address.
  logic [15:0] mem [4096];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] rd_addr_q [$];
  int          rd_cyc_q  [$];
  logic [15:0] wd_q      [$];
  logic        wl_q      [$];
  int          wc_q      [$];
  int          done_q    [$];
  logic [15:0] done_cs;
  int          busy_n, hold_err, ovf_err;
  int          s_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records reads, transfers and done; flags stall instability and overfill.
  initial begin
    int   inflight;
    logic prev_stall, prev_last, xf;
    logic [15:0] prev_data;
    inflight = 0;
    prev_stall = 1'b0;
    prev_last = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        inflight   = 0;
        prev_stall = 1'b0;
      end else begin
        xf = bus.m_valid && bus.m_ready;
        if (bus.mem_rd_en) begin
          rd_addr_q.push_back(bus.mem_rd_addr);
          rd_cyc_q.push_back(cyc);
        end
        if (xf) begin
          wd_q.push_back(bus.m_data);
          wl_q.push_back(bus.m_last);
          wc_q.push_back(cyc);
        end
        if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
          hold_err++;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        inflight   = inflight + int'(bus.mem_rd_en) - int'(xf);
        if (inflight > 2) ovf_err++;
        if (busy) busy_n++;
        if (done) begin
          done_q.push_back(cyc);
          done_cs = checksum;
        end
      end
    end
  end

  task automatic clear_mon();
    rd_addr_q.delete(); rd_cyc_q.delete();
    wd_q.delete(); wl_q.delete(); wc_q.delete(); done_q.delete();
    busy_n = 0; hold_err = 0; ovf_err = 0; done_cs = '0;
  endtask

  task automatic start_burst(input logic [11:0] base, input int cnt);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = 13'(cnt);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 12'h5A5; count = 13'h1FFF;
  endtask

  task automatic wait_done(input string tag, input bit tog);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      if (tog) bus.m_ready = ~bus.m_ready;
    end
    check_val({tag, ".done_seen"}, got, 1);
  endtask

  task automatic check_burst(input string tag, input logic [11:0] base, input int cnt,
                             input bit timed);
    check_val({tag, ".n_reads"}, rd_addr_q.size(), cnt);
    check_val({tag, ".n_words"}, wd_q.size(), cnt);
    check_val({tag, ".n_done"}, done_q.size(), 1);
    for (int i = 0; i < cnt && i < rd_addr_q.size() && i < wd_q.size(); i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      check_val($sformatf("%s.addr%0d", tag, i), rd_addr_q[i], a);
      check_val($sformatf("%s.data%0d", tag, i), wd_q[i], 16'h5000 | 16'(a));
      check_val($sformatf("%s.last%0d", tag, i), wl_q[i], (i == cnt - 1));
      if (timed) begin
        check_val($sformatf("%s.rd_cyc%0d", tag, i), rd_cyc_q[i], s_cyc + 1 + i);
        check_val($sformatf("%s.wd_cyc%0d", tag, i), wc_q[i], s_cyc + 3 + i);
      end
    end
    if (timed && done_q.size() > 0) begin
      check_val({tag, ".done_cyc"}, done_q[0], s_cyc + cnt + 3);
      check_val({tag, ".busy_cycles"}, busy_n, cnt + 2);
    end
    check_val({tag, ".hold_err"}, hold_err, 0);
    check_val({tag, ".overfill"}, ovf_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".done"}, done, 0);
    check_val({tag, ".rd_en"}, bus.mem_rd_en, 0);
    check_val({tag, ".rd_addr"}, bus.mem_rd_addr, 0);
    check_val({tag, ".m_valid"}, bus.m_valid, 0);
    check_val({tag, ".m_data"}, bus.m_data, 0);
    check_val({tag, ".m_last"}, bus.m_last, 0);
    check_val({tag, ".checksum"}, checksum, 0);
  endtask

  initial begin
    bit got;
    logic [15:0] exp_cs;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h5000 | 16'(i);
    mem[12'h100] = 16'h8000;
    mem[12'h101] = 16'h8001;
    mem[12'h102] = 16'h0003;
    resetn = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    bus.m_ready = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    resetn = 1'b1;

    // Basic burst, ready held high.
    clear_mon();
    start_burst(12'h010, 4);
    wait_done("basic", 1'b0);
    check_burst("basic", 12'h010, 4, 1'b1);

    // Ready toggling every cycle.
    clear_mon();
    bus.m_ready = 1'b1;
    start_burst(12'h040, 8);
    wait_done("toggle", 1'b1);
    check_burst("toggle", 12'h040, 8, 1'b0);
    bus.m_ready = 1'b1;

    // Address wrap at the top of memory.
    clear_mon();
    start_burst(12'hFFE, 4);
    wait_done("wrap", 1'b0);
    check_burst("wrap", 12'hFFE, 4, 1'b1);

    // Zero-length request.
    clear_mon();
    start_burst(12'h123, 0);
    wait_done("zero", 1'b0);
    check_val("zero.n_reads", rd_addr_q.size(), 0);
    check_val("zero.busy_cycles", busy_n, 0);
    check_val("zero.n_done", done_q.size(), 1);
    if (done_q.size() > 0) check_val("zero.done_cyc", done_q[0], s_cyc + 1);

    // Reset after the second word of a 10-word burst.
    clear_mon();
    start_burst(12'h200, 10);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (wd_q.size() >= 2) got = 1'b1;
    end
    check_val("rst.two_words", got, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    check_val("rst.quiet_reads", rd_addr_q.size(), 0);
    check_val("rst.quiet_words", wd_q.size(), 0);
    check_val("rst.quiet_busy", busy_n, 0);
    clear_mon();
    start_burst(12'h000, 2);
    wait_done("after_rst", 1'b0);
    check_burst("after_rst", 12'h000, 2, 1'b1);

    // Checksum: 0x8000 + 0x8001 + 0x0003 wraps to 0x0004.
`ifdef BRAM_READER_CHECKSUM_EN
    exp_cs = 16'h0004;
`else
    exp_cs = 16'h0000;
`endif
    clear_mon();
    start_burst(12'h100, 3);
    wait_done("csum", 1'b0);
    check_val("csum.n_words", wd_q.size(), 3);
    check_val("csum.value", done_cs, exp_cs);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 16: number of 256-word BRAM blocks behind the read port.
REQ-002 SHALL derive localparam ADDR_W = 8 + $clog2(NUM_BLOCKS), the memory word-address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a burst, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W: first word address, captured on an accepted start.
REQ-007 SHALL have port count, input, ADDR_W+1: number of words to read, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until the cycle done pulses.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at the end of each burst.
REQ-010 SHALL have port mem_rd_en, output, 1: read enable to the memory.
REQ-011 SHALL have port mem_rd_addr, output, ADDR_W: memory read address.
REQ-012 SHALL have port mem_rd_data, input, 16: memory read data, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port m_valid, m_ready and m_data[15:0]: output stream handshake; m_valid and m_data are outputs and m_ready is an input.
REQ-014 SHALL have port m_last, output, 1: high with the final word of the burst.
REQ-015 SHALL have port checksum, output, 16: running word checksum (see REQ-031).

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, with transitions IDLE->RUN on start with count>0, RUN->DRAIN once count reads are issued, and DRAIN->IDLE when the last word is transferred.
REQ-017 SHALL, on start with count==0 in IDLE, pulse done the next cycle, issue no read and never assert busy.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL issue the first read (mem_rd_en=1, mem_rd_addr=base_addr) in the cycle after start is accepted.
REQ-020 SHALL increment the read address modulo 2^ADDR_W, so the top address wraps to 0.
REQ-021 SHALL capture mem_rd_data into a 2-entry output FIFO in the cycle after its read, so the first word is offered on m_valid at start cycle + 3.
REQ-022 SHALL assert mem_rd_en only when FIFO occupancy plus outstanding reads is less than 2, so no word is ever dropped.
REQ-023 SHALL sustain one word per cycle while m_ready is held high.
REQ-024 SHALL transfer a word only when m_valid and m_ready are both high in the same cycle.
REQ-025 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-026 SHALL deliver words in address order, exactly count words, with m_last on the count-th word only.
REQ-027 SHALL pulse done, and drop busy, in the cycle after the m_last word is transferred.
REQ-028 SHALL accept a new start in the cycle after done.

Reset
REQ-029 SHALL, while resetn=0, force IDLE with busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, m_valid=0, m_data=0, m_last=0, checksum=0, and an empty FIFO.
REQ-030 SHALL, on reset in mid-burst, abandon the burst immediately, with no further reads or words after resetn rises and until a new start.

Configuration
REQ-031 SHALL, with BRAM_READER_CHECKSUM_EN defined, clear checksum on accepted start and add each transferred word modulo 2^16, so checksum is final when done pulses.
REQ-032 SHALL, without BRAM_READER_CHECKSUM_EN, tie checksum to 0 and contain no checksum logic.

Verification
REQ-033 SHALL cover: base=0x010, count=4, m_ready=1 -> addresses 0x010..0x013 on consecutive cycles, 4 words back to back, m_last on word 4, done one cycle later.
REQ-034 SHALL cover: m_ready toggling 1/0 each cycle, count=8 -> all 8 words in order, none duplicated or lost, m_data held while stalled, mem_rd_en never violating REQ-022.
REQ-035 SHALL cover: NUM_BLOCKS=16, base=0xFFE, count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 SHALL cover: start with count=0 -> done the next cycle, busy never high, no mem_rd_en.
REQ-037 SHALL cover: resetn low after word 2 of a count=10 burst -> all outputs at reset values, then a new burst with base=0x000, count=2 completes normally.
REQ-038 SHALL cover: with BRAM_READER_CHECKSUM_EN, words 0x8000, 0x8001, 0x0003 -> checksum 0x0004 at done; without the macro -> checksum 0.
